// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the
// clocks-per-bit helper that the transmitter also uses.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  function automatic int clks_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input; both flops
// take RST_VAL during reset so an idle-high line reads as idle.
module uart_sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_deserializer.sv
// 8N1 receiver: mid-bit majority sampling, stop-bit check, and a held byte
// with ready/overrun flags for the consumer.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 10000000,
  parameter int BAUD_RATE  = 1500000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 data_ready,
  output logic                 overrun,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int N  = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int H  = N / 2;
  localparam int CW = $clog2(N);

  localparam logic [CW-1:0] C_A    = CW'(H - 1);
  localparam logic [CW-1:0] C_B    = CW'(H);
  localparam logic [CW-1:0] C_C    = CW'(H + 1);
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);
  localparam logic [2:0]    B_LAST = 3'(DATA_BITS - 1);

  generate
    if (N < 4) begin : g_bad_n
      $error("uart_rx_deserializer: CLOCK_FREQ/BAUD_RATE must be at least 4");
    end
  endgenerate

  rx_state_t            state;
  logic [CW-1:0]        cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] sr;
  logic                 rx_s, rx_s_d;
  logic                 samp_a, samp_b, vote;
  logic                 maj, bit_val, start_det;

  uart_sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (rx_s)
  );

  // Third vote sample is the live rx_s at cnt=H+1, so maj is only meaningful then.
  assign maj       = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
  assign bit_val   = (cnt == C_C) ? maj : vote;
  assign start_det = rx_s_d & ~rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      sr         <= '0;
      rx_s_d     <= 1'b1;
      samp_a     <= 1'b0;
      samp_b     <= 1'b0;
      vote       <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      data_ready <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      rx_s_d    <= rx_s;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (rd_ack) begin
        data_ready <= 1'b0;
        overrun    <= 1'b0;
      end
      if (cnt == C_A) samp_a <= rx_s;
      if (cnt == C_B) samp_b <= rx_s;
      if (cnt == C_C) vote   <= maj;

      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (start_det) begin
            state   <= START;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (cnt == C_C && maj) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
            cnt     <= '0;
          end else if (cnt == C_LAST) begin
            state <= DATA;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == C_LAST) begin
            sr      <= {bit_val, sr[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 3'd1;
            cnt     <= '0;
            if (bit_idx == B_LAST) state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          // Decide mid stop bit and return to IDLE early so a tight next start is caught.
          if (cnt == C_C) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
            cnt     <= '0;
            if (maj) begin
              rx_data    <= sr;
              rx_valid   <= 1'b1;
              data_ready <= 1'b1;
              overrun    <= rd_ack ? 1'b0 : (data_ready | overrun);
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
          cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: frames driven serially, expected
// bytes and launch cycles queued, popped and checked on each rx_valid.
module tb_uart_rx_deserializer;

  localparam int N   = 6;
  localparam int H   = 3;
  localparam int LAT = 9 * N + H + 4;

  logic       clk_10ns = 1'b0;
  logic       rst, rx_in, rd_ack;
  logic [7:0] rx_data;
  logic       rx_valid, data_ready, overrun, frame_err, rx_busy;

  uart_rx_deserializer #(.CLOCK_FREQ(10000000), .BAUD_RATE(1500000)) dut (
    .clk        (clk_10ns),
    .rst        (rst),
    .rx_in      (rx_in),
    .rd_ack     (rd_ack),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .data_ready (data_ready),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .rx_busy    (rx_busy)
  );

  always #5 clk_10ns = ~clk_10ns;

  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0, errors = 0;
  int   vcnt = 0, fecnt = 0, busy_run = 0, busy_max = 0;

  always @(posedge clk_10ns) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs observed on the falling edge, rx_valid scored here.
  task automatic tick();
    exp_t e;
    int   lat;
    @(negedge clk_10ns);
    if (rx_busy === 1'b1) begin
      busy_run++;
      if (busy_run > busy_max) busy_max = busy_run;
    end else begin
      busy_run = 0;
    end
    if (frame_err === 1'b1) fecnt++;
    if (rx_valid === 1'b1) begin
      vcnt++;
      chk("rx_valid_expected", (sb.size() > 0) ? 1 : 0, 1);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        lat = cyc - e.start;
        chk("rx_data", 32'(rx_data), 32'(e.data));
        chk("latency_window", (lat >= LAT - 1 && lat <= LAT + 1) ? 1 : 0, 1);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    exp_t e;
    rx_in   = 1'b0;
    e.data  = b;
    e.start = cyc + 1;
    if (stop) sb.push_back(e);
    repeat (N) tick();
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (N) tick();
    end
    rx_in = stop;
    repeat (N) tick();
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 30) begin
      tick();
      n++;
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic ack();
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
  endtask

  initial begin
    int         v0, f0;
    logic [7:0] b6;
    rst = 1'b1; rx_in = 1'b1; rd_ack = 1'b0;
    idle(3);
    chk("reset_outputs", 32'({rx_data, rx_valid, data_ready, overrun, frame_err, rx_busy}), 0);
    rst = 1'b0;
    idle(3);

    // single byte, latency checked in tick()
    send(8'h02, 1'b1); idle(4); drain();
    chk("t1_data_ready", 32'(data_ready), 1);
    chk("t1_overrun", 32'(overrun), 0);
    chk("t1_frame_err", fecnt, 0);
    chk("t1_valid_count", vcnt, 1);
    ack();
    chk("t1_ack_clears", 32'(data_ready), 0);

    // read between two frames
    v0 = vcnt;
    send(8'h0A, 1'b1); idle(4); drain();
    ack();
    chk("t2_ready_cleared", 32'(data_ready), 0);
    send(8'h0A, 1'b1); idle(4); drain();
    chk("t2_valid_count", vcnt - v0, 2);
    chk("t2_data_ready", 32'(data_ready), 1);
    chk("t2_overrun", 32'(overrun), 0);
    ack();

    // 2-clock glitch
    v0 = vcnt; f0 = fecnt; busy_max = 0; busy_run = 0;
    rx_in = 1'b0; tick(); tick(); rx_in = 1'b1;
    idle(15);
    chk("t3_busy_bounded", (busy_max > 0 && busy_max <= H + 2) ? 1 : 0, 1);
    chk("t3_no_valid", vcnt - v0, 0);
    chk("t3_no_frame_err", fecnt - f0, 0);
    chk("t3_rx_data_held", 32'(rx_data), 32'h0A);

    // bad stop bit, line then held low as a break
    v0 = vcnt; f0 = fecnt;
    send(8'h55, 1'b0);
    idle(40);
    chk("t4_frame_err_once", fecnt - f0, 1);
    chk("t4_no_valid", vcnt - v0, 0);
    chk("t4_data_ready", 32'(data_ready), 0);
    chk("t4_idle_in_break", 32'(rx_busy), 0);
    chk("t4_rx_data_held", 32'(rx_data), 32'h0A);
    rx_in = 1'b1; idle(5);
    chk("t4_no_more_err", fecnt - f0, 1);

    // back-to-back without reading
    v0 = vcnt;
    send(8'h55, 1'b1); send(8'hAA, 1'b1); idle(4); drain();
    chk("t5_valid_count", vcnt - v0, 2);
    chk("t5_rx_data", 32'(rx_data), 32'hAA);
    chk("t5_data_ready", 32'(data_ready), 1);
    chk("t5_overrun", 32'(overrun), 1);
    ack();
    chk("t5_ack_clears_both", 32'({data_ready, overrun}), 0);

    // reset during bit 4 of 0xC3, held until the line is high again
    v0 = vcnt; f0 = fecnt; b6 = 8'hC3;
    rx_in = 1'b0; repeat (N) tick();
    for (int i = 0; i < 8; i++) begin
      rx_in = b6[i];
      if (i == 4) begin
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("t6_reset_outputs", 32'({rx_data, rx_valid, data_ready, overrun, frame_err, rx_busy}), 0);
        repeat (N - 3) tick();
      end else if (i == 6) begin
        repeat (3) tick();
        rst = 1'b0;
        repeat (N - 3) tick();
      end else begin
        repeat (N) tick();
      end
    end
    rx_in = 1'b1; repeat (N) tick();
    idle(10);
    chk("t6_aborted_no_valid", vcnt - v0, 0);
    chk("t6_aborted_no_err", fecnt - f0, 0);
    chk("t6_idle", 32'(rx_busy), 0);
    send(8'h3C, 1'b1); idle(4); drain();
    chk("t6_next_valid", vcnt - v0, 1);
    chk("t6_next_data", 32'(rx_data), 32'h3C);
    chk("t6_next_ready", 32'(data_ready), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- Serial-to-parallel receive stage that consumes the 8N1 serial stream produced by the project's UART transmitter (loopback path tx_d_out -> rx_d_in).
- Recovers bytes by mid-bit majority sampling, checks the stop bit, and holds the byte for the on-chip consumer until it is read.
- Sits between the rx pin (uio_in[0]) and the uo_out / uio_out[0] status path of tt_um_uart_8bit.

Parameters:
- CLOCK_FREQ, 10000000, system clock frequency in Hz.
- BAUD_RATE, 1500000, serial bit rate in bits/s.
- N (localparam), CLOCK_FREQ/BAUD_RATE using integer division (default 6), clocks per bit. Elaboration fails if N < 4.
- H (localparam), N/2 (default 3), centre-of-bit offset.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- rx_in  in  1  asynchronous serial line; idle high.
- rd_ack  in  1  one-cycle consumer pulse; clears data_ready and overrun.
- rx_data  out  8  last good byte; holds its value until the next good byte.
- rx_valid  out  1  one-cycle pulse when a good byte is loaded into rx_data.
- data_ready  out  1  level; an unread byte is present.
- overrun  out  1  sticky; a good byte arrived while data_ready was 1.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled as 0.
- rx_busy  out  1  high whenever the state machine is not in IDLE.

Behaviour:
- Reset: state=IDLE. rx_data=0x00, and rx_valid, data_ready, overrun, frame_err, rx_busy are all 0. Both synchronizer flops are forced to 1. The bit and sample counters are cleared.
- Reset asserted mid-frame aborts the frame with no output pulse. After release, reception resumes only on a new falling edge.
- Synchronizer: rx_in passes through 2 flops to give rx_s. rx_s_d is rx_s delayed by one clock. A start is detected when rx_s_d=1 and rx_s=0.
- Counter cnt runs 0..N-1 within each bit cell. A majority vote of rx_s is taken at cnt=H-1, H and H+1.
- IDLE: on start detect, go to START with cnt=0 and bit_idx=0.
- START:
  - At cnt=H+1, if the vote is 1 (glitch), return to IDLE with no pulse.
  - Otherwise, at cnt=N-1, set cnt=0 and go to DATA.
- DATA:
  - At cnt=N-1, shift the vote into the shift register MSB (shift right, so the byte is received LSB first).
  - Increment bit_idx; after bit_idx=7, go to STOP.
- STOP: decide at cnt=H+1, then go to IDLE in the same edge. IDLE is not delayed to the end of the stop bit, so an early next start is accepted.
  - Vote = 1: rx_data <= shift register; rx_valid and data_ready go to 1 on the next edge. If data_ready was already 1 and rd_ack is not asserted in that cycle, overrun <= 1. The new byte overwrites the old one.
  - Vote = 0: frame_err pulses for one cycle. rx_data and data_ready are unchanged. Because IDLE requires a falling edge, a held-low break line cannot retrigger reception.
- rd_ack: clears data_ready and overrun on the next edge.
  - If a good byte loads in the same cycle, the load wins: data_ready=1 and overrun=0.
  - rd_ack while data_ready=0 has no effect.
- Latency: the rx_valid rise occurs 9*N + H + 4 clocks after the first edge that samples rx_in low. The bench accepts ±1 clock (synchronizer phase).
- Widths:
  - cnt: $clog2(N) bits.
  - bit_idx: 3 bits, wrapping 7 -> 0 on the STOP entry.
- No baud-error tolerance beyond what mid-bit sampling provides. With integer N, the transmitter must use the same N.

Decomposition:
- uart_pkg holds:
  - typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  - function clks_per_bit(CLOCK_FREQ, BAUD_RATE), shared with the transmitter;
  - the constant DATA_BITS = 8.
- One sub-module: uart_sync_2ff, a 2-flop synchronizer with a reset value parameter (set to 1 here).

Test Plan:
- Send 0x02 as 8N1 at N=6 clocks/bit -> one rx_valid pulse and rx_data=0x02 at 9*6+3+4=61 ±1 clocks; data_ready=1, overrun=0, frame_err=0.
- Send 0x0A, pulse rd_ack, send 0x0A again -> two rx_valid pulses, data_ready cleared between them, overrun=0.
- Drive rx_in low for 2 clocks then high -> rx_busy high for at most H+2 clocks; no rx_valid or frame_err pulse; rx_data unchanged.
- Send 0x55 with the stop bit forced to 0 -> frame_err pulses once, no rx_valid, data_ready stays 0; holding rx_in low afterwards produces no further activity.
- Send 0x55 then 0xAA back-to-back with no rd_ack -> rx_data=0xAA, data_ready=1, overrun=1; a single rd_ack clears both.
- Assert rst during bit 4 of 0xC3 -> all outputs 0 on the next edge; the remainder of the frame is ignored; the following frame 0x3C is received correctly.
